// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetches and load/stores
// onto a single synchronous 8-bit RAM port (read data one cycle after address).
module mem_ctrl #(
    parameter int ADR_W = 16,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_i,
    input  logic             if_en_i,
    input  logic [ADR_W-1:0] if_pc_i,
    output logic             if_en_o,
    output logic [DW-1:0]    if_ins_o,
    input  logic             ls_en_i,
    input  logic             ls_wr_i,
    input  logic [1:0]       ls_len_i,
    input  logic [ADR_W-1:0] ls_adr_i,
    input  logic [DW-1:0]    ls_dat_i,
    output logic             ls_en_o,
    output logic [DW-1:0]    ls_dat_o,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [ADR_W-1:0] mem_a,
    output logic             mem_wr
);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] base_q, base_d;
    logic [2:0]       n_q, n_d;
    logic [2:0]       a_idx_q, a_idx_d;
    logic [2:0]       c_q, c_d;
    logic [DW-1:0]    buf_q, buf_d;
    logic [DW-1:0]    sdat_q, sdat_d;
    logic [ADR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]       mem_dout_q, mem_dout_d;
    logic             mem_wr_q, mem_wr_d;
    logic             if_en_q, if_en_d;
    logic             ls_en_q, ls_en_d;
    logic [DW-1:0]    if_ins_q, if_ins_d;
    logic [DW-1:0]    ls_dat_q, ls_dat_d;

    logic             if_pend_q, if_pend_d;
    logic [ADR_W-1:0] if_pc_pend_q, if_pc_pend_d;
    logic             ls_pend_q, ls_pend_d;
    logic             ls_wr_pend_q, ls_wr_pend_d;
    logic [1:0]       ls_len_pend_q, ls_len_pend_d;
    logic [ADR_W-1:0] ls_adr_pend_q, ls_adr_pend_d;
    logic [DW-1:0]    ls_dat_pend_q, ls_dat_pend_d;

    logic [2:0]       a_nxt;
    logic             ls_take, if_take, if_live;
    logic             sel_wr;
    logic [1:0]       sel_len;
    logic [ADR_W-1:0] sel_adr;
    logic [DW-1:0]    sel_dat;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   len_bytes = 3'd1;
            2'b01:   len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [ADR_W-1:0] adr_off(input logic [ADR_W-1:0] base, input logic [2:0] k);
        adr_off = base + {{(ADR_W-3){1'b0}}, k};
    endfunction

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        n_d           = n_q;
        a_idx_d       = a_idx_q;
        c_d           = c_q;
        buf_d         = buf_q;
        sdat_d        = sdat_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = mem_wr_q;
        if_en_d       = 1'b0;
        ls_en_d       = 1'b0;
        if_ins_d      = if_ins_q;
        ls_dat_d      = ls_dat_q;
        if_pend_d     = if_pend_q;
        if_pc_pend_d  = if_pc_pend_q;
        ls_pend_d     = ls_pend_q;
        ls_wr_pend_d  = ls_wr_pend_q;
        ls_len_pend_d = ls_len_pend_q;
        ls_adr_pend_d = ls_adr_pend_q;
        ls_dat_pend_d = ls_dat_pend_q;
        a_nxt         = a_idx_q + 3'd1;
        ls_take       = 1'b0;
        if_take       = 1'b0;
        if_live       = if_en_i && !clr_i;
        sel_wr        = ls_en_i ? ls_wr_i  : ls_wr_pend_q;
        sel_len       = ls_en_i ? ls_len_i : ls_len_pend_q;
        sel_adr       = ls_en_i ? ls_adr_i : ls_adr_pend_q;
        sel_dat       = ls_en_i ? ls_dat_i : ls_dat_pend_q;

        if (en) begin
            case (state_q)
                IF_RD, LS_RD: begin
                    // a_idx leads c by one once the first byte is in flight
                    if (a_idx_q != c_q) begin
                        buf_d[{c_q[1:0], 3'b000} +: 8] = mem_din;
                        c_d = c_q + 3'd1;
                        if (c_q == n_q - 3'd1) begin
                            state_d = IDLE;
                            if (state_q == IF_RD) begin
                                if_en_d  = 1'b1;
                                if_ins_d = buf_d;
                            end else begin
                                ls_en_d  = 1'b1;
                                ls_dat_d = buf_d;
                            end
                        end
                    end
                    a_idx_d = a_nxt;
                    mem_a_d = adr_off(base_q, a_nxt);
                end
                LS_WR: begin
                    if (a_idx_q == n_q - 3'd1) begin
                        mem_wr_d = 1'b0;
                        ls_en_d  = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        a_idx_d    = a_nxt;
                        mem_a_d    = adr_off(base_q, a_nxt);
                        mem_dout_d = sdat_q[{a_nxt[1:0], 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end

        if (clr_i && state_q == IF_RD) begin
            state_d  = IDLE;
            if_en_d  = 1'b0;
            if_ins_d = if_ins_q;
        end

        // a completing edge may chain straight into the next transfer
        if (en && state_d == IDLE) begin
            if (ls_en_i || ls_pend_q)
                ls_take = 1'b1;
            else if (if_live || (if_pend_q && !clr_i))
                if_take = 1'b1;
        end

        if (ls_en_i && !ls_take) begin
            ls_pend_d     = 1'b1;
            ls_wr_pend_d  = ls_wr_i;
            ls_len_pend_d = ls_len_i;
            ls_adr_pend_d = ls_adr_i;
            ls_dat_pend_d = ls_dat_i;
        end else if (ls_take) begin
            ls_pend_d = 1'b0;
        end

        if (clr_i) begin
            if_pend_d = 1'b0;
        end else if (if_live && !if_take) begin
            if_pend_d    = 1'b1;
            if_pc_pend_d = if_pc_i;
        end else if (if_take) begin
            if_pend_d = 1'b0;
        end

        if (ls_take || if_take) begin
            a_idx_d = 3'd0;
            c_d     = 3'd0;
            buf_d   = '0;
            if (ls_take) begin
                base_d  = sel_adr;
                mem_a_d = sel_adr;
                n_d     = len_bytes(sel_len);
                sdat_d  = sel_dat;
                if (sel_wr) begin
                    state_d    = LS_WR;
                    mem_wr_d   = 1'b1;
                    mem_dout_d = sel_dat[7:0];
                end else begin
                    state_d  = LS_RD;
                    mem_wr_d = 1'b0;
                end
            end else begin
                base_d   = if_live ? if_pc_i : if_pc_pend_q;
                mem_a_d  = if_live ? if_pc_i : if_pc_pend_q;
                n_d      = 3'd4;
                state_d  = IF_RD;
                mem_wr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            n_q           <= '0;
            a_idx_q       <= '0;
            c_q           <= '0;
            buf_q         <= '0;
            sdat_q        <= '0;
            mem_a_q       <= '0;
            mem_dout_q    <= '0;
            mem_wr_q      <= 1'b0;
            if_en_q       <= 1'b0;
            ls_en_q       <= 1'b0;
            if_ins_q      <= '0;
            ls_dat_q      <= '0;
            if_pend_q     <= 1'b0;
            if_pc_pend_q  <= '0;
            ls_pend_q     <= 1'b0;
            ls_wr_pend_q  <= 1'b0;
            ls_len_pend_q <= '0;
            ls_adr_pend_q <= '0;
            ls_dat_pend_q <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            n_q           <= n_d;
            a_idx_q       <= a_idx_d;
            c_q           <= c_d;
            buf_q         <= buf_d;
            sdat_q        <= sdat_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
            if_en_q       <= if_en_d;
            ls_en_q       <= ls_en_d;
            if_ins_q      <= if_ins_d;
            ls_dat_q      <= ls_dat_d;
            if_pend_q     <= if_pend_d;
            if_pc_pend_q  <= if_pc_pend_d;
            ls_pend_q     <= ls_pend_d;
            ls_wr_pend_q  <= ls_wr_pend_d;
            ls_len_pend_q <= ls_len_pend_d;
            ls_adr_pend_q <= ls_adr_pend_d;
            ls_dat_pend_q <= ls_dat_pend_d;
        end
    end

    // While paused, point the RAM at the next uncaptured byte so its data is
    // waiting on mem_din in the first cycle after en returns.
    assign mem_a    = (!en && (state_q == IF_RD || state_q == LS_RD)) ? adr_off(base_q, c_q) : mem_a_q;
    assign mem_wr   = mem_wr_q && en;
    assign mem_dout = mem_dout_q;
    assign if_en_o  = if_en_q;
    assign if_ins_o = if_ins_q;
    assign ls_en_o  = ls_en_q;
    assign ls_dat_o = ls_dat_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model, directed requests with
// hand-computed results, and a negedge monitor checking pulses and writes.
module tb_mem_ctrl;
    localparam int ADR_W = 16;
    localparam int DW    = 32;

    logic             clk = 1'b0;
    logic             rst, en, clr_i, if_en_i, ls_en_i, ls_wr_i;
    logic [1:0]       ls_len_i;
    logic [ADR_W-1:0] if_pc_i, ls_adr_i, mem_a;
    logic [DW-1:0]    ls_dat_i, if_ins_o, ls_dat_o;
    logic             if_en_o, ls_en_o, mem_wr;
    logic [7:0]       mem_din, mem_dout;

    typedef struct {logic [31:0] dat; int unsigned cyc; bit chk_dat;} exp_t;
    typedef struct {logic [15:0] adr; logic [7:0] dat;} wr_t;
    exp_t q_if[$];
    exp_t q_ls[$];
    wr_t  q_wr[$];

    int n_cmp = 0;
    int n_fail = 0;
    int unsigned edges = 0;

    logic [7:0]  ram [0:65535];
    logic [7:0]  rd_q = 8'h00;
    logic        pk_en = 1'b0;
    logic [15:0] pk_a = '0;
    logic [7:0]  pk_d = '0;

    mem_ctrl #(.ADR_W(ADR_W), .DW(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_i(clr_i),
        .if_en_i(if_en_i), .if_pc_i(if_pc_i), .if_en_o(if_en_o), .if_ins_o(if_ins_o),
        .ls_en_i(ls_en_i), .ls_wr_i(ls_wr_i), .ls_len_i(ls_len_i), .ls_adr_i(ls_adr_i),
        .ls_dat_i(ls_dat_i), .ls_en_o(ls_en_o), .ls_dat_o(ls_dat_o),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    always @(posedge clk) begin
        if (pk_en) ram[pk_a] <= pk_d;
        else if (mem_wr) ram[mem_a] <= mem_dout;
        rd_q <= ram[mem_a];
    end
    assign mem_din = rd_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, exp, edges);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pk_en = 1'b1; pk_a = a; pk_d = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    task automatic issue_if(input logic [15:0] pc, input logic [31:0] exp);
        @(posedge clk); #1;
        if_en_i = 1'b1; if_pc_i = pc;
        q_if.push_back('{exp, edges + 6, 1'b1});
        @(posedge clk); #1;
        if_en_i = 1'b0;
    endtask

    // lat counts edges from the issuing edge to the completion edge
    task automatic issue_ls(input logic wr, input logic [1:0] len, input logic [15:0] adr,
                            input logic [31:0] dat, input logic [31:0] exp, input int unsigned lat);
        @(posedge clk); #1;
        ls_en_i = 1'b1; ls_wr_i = wr; ls_len_i = len; ls_adr_i = adr; ls_dat_i = dat;
        q_ls.push_back('{exp, edges + lat, !wr});
        @(posedge clk); #1;
        ls_en_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (q_if.size() == 0 && q_ls.size() == 0 && q_wr.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain_timeout", q_if.size() + q_ls.size() + q_wr.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_en_o && ls_en_o) chk("both_pulses", {31'd0, ls_en_o}, 32'd0);
                if (if_en_o) begin
                    if (q_if.size() == 0) chk("if_unexpected", {31'd0, if_en_o}, 32'd0);
                    else begin
                        e = q_if.pop_front();
                        chk("if_ins", if_ins_o, e.dat);
                        chk("if_edge", edges, e.cyc);
                    end
                end
                if (ls_en_o) begin
                    if (q_ls.size() == 0) chk("ls_unexpected", {31'd0, ls_en_o}, 32'd0);
                    else begin
                        e = q_ls.pop_front();
                        if (e.chk_dat) chk("ls_dat", ls_dat_o, e.dat);
                        chk("ls_edge", edges, e.cyc);
                    end
                end
                if (mem_wr) begin
                    if (q_wr.size() == 0) chk("wr_unexpected", {31'd0, mem_wr}, 32'd0);
                    else begin
                        w = q_wr.pop_front();
                        chk("wr_adr", {16'd0, mem_a}, {16'd0, w.adr});
                        chk("wr_dat", {24'd0, mem_dout}, {24'd0, w.dat});
                    end
                end
                if (!en) chk("wr_in_pause", {31'd0, mem_wr}, 32'd0);
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_a"}, {16'd0, mem_a}, 32'd0);
        chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
        chk({tag, "_if_en_o"}, {31'd0, if_en_o}, 32'd0);
        chk({tag, "_ls_en_o"}, {31'd0, ls_en_o}, 32'd0);
        chk({tag, "_if_ins_o"}, if_ins_o, 32'd0);
        chk({tag, "_ls_dat_o"}, ls_dat_o, 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr_i = 1'b0; if_en_i = 1'b0; if_pc_i = '0;
        ls_en_i = 1'b0; ls_wr_i = 1'b0; ls_len_i = '0; ls_adr_i = '0; ls_dat_i = '0;

        poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h10); poke(16'h0103, 8'h00);
        poke(16'h0104, 8'h93); poke(16'h0105, 8'h02); poke(16'h0106, 8'h00); poke(16'h0107, 8'h01);
        poke(16'h0010, 8'h5A); poke(16'hFFFF, 8'h34); poke(16'h0000, 8'h12);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // instruction fetch at 0x100
        issue_if(16'h0100, 32'h00100513);
        wait_done();

        // word store then half load from the upper half
        q_wr.push_back('{16'h0200, 8'hEF}); q_wr.push_back('{16'h0201, 8'hBE});
        q_wr.push_back('{16'h0202, 8'hAD}); q_wr.push_back('{16'h0203, 8'hDE});
        issue_ls(1'b1, 2'b10, 16'h0200, 32'hDEADBEEF, 32'h0, 5);
        wait_done();
        issue_ls(1'b0, 2'b01, 16'h0202, 32'h0, 32'h0000DEAD, 4);
        wait_done();

        // simultaneous requests: LS byte first, IF chained on its completion edge
        @(posedge clk); #1;
        if_en_i = 1'b1; if_pc_i = 16'h0104;
        ls_en_i = 1'b1; ls_wr_i = 1'b0; ls_len_i = 2'b00; ls_adr_i = 16'h0010;
        q_ls.push_back('{32'h0000005A, edges + 3, 1'b1});
        q_if.push_back('{32'h01000293, edges + 8, 1'b1});
        @(posedge clk); #1;
        if_en_i = 1'b0; ls_en_i = 1'b0;
        wait_done();

        // flush two edges into a fetch, then a fresh fetch
        @(posedge clk); #1;
        if_en_i = 1'b1; if_pc_i = 16'h0100;
        @(posedge clk); #1;
        if_en_i = 1'b0;
        @(posedge clk); #1;
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        issue_if(16'h0104, 32'h01000293);
        wait_done();

        // word load paused for three cycles
        @(posedge clk); #1;
        ls_en_i = 1'b1; ls_wr_i = 1'b0; ls_len_i = 2'b10; ls_adr_i = 16'h0200;
        q_ls.push_back('{32'hDEADBEEF, edges + 9, 1'b1});
        @(posedge clk); #1;
        ls_en_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        wait_done();

        // address wrap, len 11 as word, byte store/load
        issue_ls(1'b0, 2'b01, 16'hFFFF, 32'h0, 32'h00001234, 4);
        wait_done();
        issue_ls(1'b0, 2'b11, 16'h0100, 32'h0, 32'h00100513, 6);
        wait_done();
        q_wr.push_back('{16'h0400, 8'h77});
        issue_ls(1'b1, 2'b00, 16'h0400, 32'hAABBCC77, 32'h0, 2);
        wait_done();
        issue_ls(1'b0, 2'b00, 16'h0400, 32'h0, 32'h00000077, 3);
        wait_done();

        // reset after two bytes of a word store
        @(posedge clk); #1;
        ls_en_i = 1'b1; ls_wr_i = 1'b1; ls_len_i = 2'b10; ls_adr_i = 16'h0300; ls_dat_i = 32'h11223344;
        q_wr.push_back('{16'h0300, 8'h44}); q_wr.push_back('{16'h0301, 8'h33});
        @(posedge clk); #1;
        ls_en_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_wr_left", q_wr.size(), 0);
        chk("ram_300", {24'd0, ram[16'h0300]}, 32'h44);
        chk("ram_301", {24'd0, ram[16'h0301]}, 32'h33);
        chk("ram_302", {24'd0, ram[16'h0302]}, 32'h00);
        chk("ram_303", {24'd0, ram[16'h0303]}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: ADR_W, `RAM_ADR_W, byte-address width of RAM and request ports.
REQ-002 Parameter: DW, `DAT_W (32), instruction/data word width.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 en  in  1  global run enable; 0 = pause.
REQ-006 clr_i  in  1  pipeline flush; abandons instruction traffic only.
REQ-007 if_en_i  in  1  one-cycle instruction-fetch request pulse from instruction cache.
REQ-008 if_pc_i  in  ADR_W  fetch address, word-aligned, valid with if_en_i.
REQ-009 if_en_o  out  1  one-cycle pulse: if_ins_o valid.
REQ-010 if_ins_o  out  DW  fetched instruction, little-endian.
REQ-011 ls_en_i  in  1  one-cycle load/store request pulse.
REQ-012 ls_wr_i  in  1  1 = store, 0 = load.
REQ-013 ls_len_i  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-014 ls_adr_i  in  ADR_W  load/store byte address.
REQ-015 ls_dat_i  in  DW  store data, low bytes used.
REQ-016 ls_en_o  out  1  one-cycle completion pulse for load or store.
REQ-017 ls_dat_o  out  DW  load data, zero-extended.
REQ-018 mem_din  in  8  RAM read byte for address presented previous cycle.
REQ-019 mem_dout  out  8  RAM write byte.
REQ-020 mem_a  out  ADR_W  RAM byte address.
REQ-021 mem_wr  out  1  RAM write strobe, 1 = write.

Function
REQ-022 States SHALL be IDLE, IF_RD, LS_RD, LS_WR; one transfer in flight at a time.
REQ-023 Requests arriving while not IDLE SHALL be latched into a one-deep pending slot per port (IF, LS) and served later; a newer pulse on the same port overwrites its slot.
REQ-024 In IDLE, LS (live or pending) SHALL take priority over IF; the accept edge loads mem_a with byte 0 address and enters the transfer state.
REQ-025 Reads: mem_a SHALL step base, base+1, ... one byte per cycle; byte k captured two edges after its address edge, placed at bits [8k+7:8k].
REQ-026 IF read of 4 bytes: if_en_o SHALL pulse, with if_ins_o, exactly 5 edges after accept edge; state returns IDLE same edge.
REQ-027 LS load of n bytes (1/2/4): ls_en_o SHALL pulse n+1 edges after accept; unused ls_dat_o bits zero.
REQ-028 LS store of n bytes: mem_wr=1 with byte k of ls_dat_i at base+k on edges 0..n-1 after accept; mem_wr=0 and ls_en_o pulse on edge n.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADR_W.
REQ-030 mem_wr SHALL be 0 in every cycle not driving a store byte.
REQ-031 clr_i=1 SHALL abort IF_RD (no if_en_o pulse), clear IF pending slot, and return IDLE next edge; LS_RD/LS_WR and LS pending SHALL be unaffected.
REQ-032 clr_i and if_en_i same cycle: request dropped.
REQ-033 en=0: all registers hold, mem_wr forced 0, no byte captured; on resume mem_a re-presents base+(bytes captured) and reading continues.
REQ-034 if_en_o and ls_en_o SHALL never be high more than one cycle per request and never high together.

Reset
REQ-035 rst=1 asynchronously: state IDLE, pending slots cleared, mem_a=0, mem_dout=0, mem_wr=0, if_en_o=0, ls_en_o=0, if_ins_o=0, ls_dat_o=0.
REQ-036 Reset mid-transfer SHALL discard the transfer with no completion pulse after release.

Verification
REQ-037 RAM[0x100..0x103]=13 05 10 00; if_en_i pulse pc=0x100 -> if_en_o one cycle, 5 edges later, if_ins_o=0x00100513.
REQ-038 Store word 0xDEADBEEF at 0x200 -> mem_wr 4 cycles, bytes EF BE AD DE at 0x200..0x203, ls_en_o on edge 4; then half load 0x202 -> ls_dat_o=0x0000DEAD at edge 3.
REQ-039 if_en_i and ls_en_i (load byte 0x10) same cycle -> LS served first, then IF; IF result arrives 5 edges after LS completion edge.
REQ-040 clr_i asserted 2 edges into IF read of 0x100 -> no if_en_o, controller IDLE, next IF request at 0x104 completes normally.
REQ-041 en low 3 cycles mid word load -> data still correct, ls_en_o delayed by 3 cycles, no mem_wr during pause.
REQ-042 rst pulsed mid store after 2 bytes -> all outputs zero immediately, no ls_en_o afterward, only 2 bytes written.
